vector_writeback_unit: RTL and testbench
========================================

Name: vector_writeback_unit

Overview:
- Writeback stage directly upstream of the vector register file.
- Collects completed results from the execute pipe and the memory/load pipe through valid/ready handshakes, and buffers them in a small FIFO.
- Retires one entry per cycle into the register file: data write, scoreboard mark-valid, and machine-flag/halt updates.
- Decouples producer bursts from the register file's single write port.

Parameters:
- NUM_LANES, 8, lanes per VectorValue
- LANE_W, 64, bits per lane
- REG_ID_W, 5, register id width
- MAX_REG_ID, 32, number of architectural registers; id >= MAX_REG_ID is illegal
- DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- ex_valid  in  1  execute result present
- ex_ready  out  1  execute result accepted this cycle when ex_valid && ex_ready
- ex_id  in  REG_ID_W  destination register
- ex_value  in  NUM_LANES*LANE_W  result vector
- ex_flags  in  64  machine-flag bits to OR in at retire
- ex_halt  in  1  result carries halt
- mem_valid / mem_ready / mem_id / mem_value  in/out/in/in  1/1/REG_ID_W/NUM_LANES*LANE_W  load result, same handshake
- rf_wr_en  out  1  register write strobe
- rf_wr_id  out  REG_ID_W  register index
- rf_wr_value  out  NUM_LANES*LANE_W  write data
- rf_mark_valid  out  1  scoreboard written-counter increment, same id
- rf_flags_en  out  1  OR rf_flags into machine flags
- rf_flags  out  64  flag bits
- rf_set_halt  out  1  one-cycle halt pulse
- halted  out  1  sticky: halt entry retired
- err_bad_reg  out  1  sticky: illegal id seen
- occupancy  out  clog2(DEPTH)+1  current FIFO fill

Behaviour:
- Reset (clk edge with reset_n=0):
  - FIFO emptied; in-flight entries are discarded, never written.
  - Round-robin pointer favours ex.
  - Every output is 0, except ex_ready/mem_ready, which are 1 in the first cycle after reset.
- Ready generation is registered-free combinational from occupancy and halted:
  - free >= 2: both readies = 1.
  - free == 1: ready only to the round-robin winner; a sole valid requester gets it regardless of pointer.
  - free == 0 or halted: both readies = 0.
- Enqueue order when both fire in the same cycle: mem entry first, ex entry second.
- Round-robin pointer flips only after a free==1 contention cycle.
- Entry format: {id, value, flags, halt, is_ex}; mem entries carry flags=0, halt=0.
- Retire:
  - Head entry is presented combinationally on rf_* outputs when the FIFO is non-empty at the start of the cycle, and popped at that cycle's clock edge.
  - Latency: accepted at edge N, visible on rf_* during cycle N+1, written at edge N+1. No bypass to same-cycle output.
  - rf_wr_en = rf_mark_valid = 1 for a legal id.
  - rf_flags_en = 1 iff flags != 0.
  - rf_set_halt = 1 iff halt.
- Simultaneous push and pop: allowed. Occupancy = old + pushes − pop, computed before readies for the next cycle.
- Illegal id:
  - Entry is still accepted and popped in order.
  - rf_wr_en = rf_mark_valid = 0; flags/halt still apply.
  - err_bad_reg set, cleared only by reset.
- Halt:
  - On halt retire, halted is set.
  - Younger entries already queued still retire in order.
  - Readies stay 0 until reset.
- Wrap-around: read/write pointers are log2(DEPTH)+1 bits. Full when MSBs differ and LSBs are equal; empty when all bits are equal.
- Producer rules: values are held stable while valid && !ready. Dropping valid without a handshake is legal.

Decomposition:
- Shared package (existing CPU types package): VectorValue, RegisterID, MAX_REG_ID, flags_reg_t, MACHINE_FLAGS_MASK_HALT, and a new wb_entry_t struct.
- One sub-module: wb_fifo (parameterised DEPTH, single read port, up to two writes per cycle, occupancy output).
- Arbitration and retire logic stay in the top.

Test Plan:
- Single ex write:
  - Stimulus: ex id=3, value=all lanes 0xA5, flags=0, accepted at edge 0.
  - Response: cycle 1 rf_wr_en=1, rf_mark_valid=1, rf_wr_id=3, rf_flags_en=0; cycle 2 FIFO empty, all strobes 0.
- Dual enqueue:
  - Stimulus: ex id=1 and mem id=2 both valid at occupancy 0.
  - Response: both readies 1; retires id=2 in cycle 1, then id=1 in cycle 2; occupancy goes 2→1→0.
- Full/backpressure:
  - Stimulus: hold both valid continuously with DEPTH=4.
  - Response: occupancy never exceeds 4; at free==1 grants alternate ex/mem; no entry lost or duplicated across 20 retires (id sequence checked).
- Illegal id plus flags:
  - Stimulus: ex id=40 (REG_ID_W=6 build, MAX_REG_ID=32), flags=0x4.
  - Response: rf_wr_en=0, rf_flags_en=1, rf_flags=0x4, err_bad_reg=1 and stays 1.
- Halt:
  - Stimulus: queue ex halt entry, then mem id=7 behind it.
  - Response: rf_set_halt pulses exactly one cycle; halted=1; id=7 still written the next cycle; readies stay 0 for 10 cycles.
- Reset mid-operation:
  - Stimulus: occupancy=3, reset_n=0 for one edge.
  - Response: next cycle occupancy=0, rf_wr_en=0, halted=0, err_bad_reg=0, readies=1; the 3 queued ids never appear on rf_wr_id.

Source files
------------

// File: rtl/vector_writeback_unit_pkg.sv
// Shared CPU types for the vector writeback path: register/vector widths,
// machine-flag register type and the default-configuration writeback entry.
package vector_writeback_unit_pkg;

   localparam int unsigned VWB_NUM_LANES  = 8;
   localparam int unsigned VWB_LANE_W     = 64;
   localparam int unsigned VWB_REG_ID_W   = 5;
   localparam int unsigned VWB_MAX_REG_ID = 32;
   localparam int unsigned VWB_FLAGS_W    = 64;

   typedef logic [VWB_NUM_LANES*VWB_LANE_W-1:0] VectorValue;
   typedef logic [VWB_REG_ID_W-1:0]             RegisterID;
   typedef logic [VWB_FLAGS_W-1:0]              flags_reg_t;

   localparam flags_reg_t MACHINE_FLAGS_MASK_HALT = 64'h1;

   // Entry layout for the default build; parameterised builds use the same field order.
   typedef struct packed {
      RegisterID  id;
      VectorValue value;
      flags_reg_t flags;
      logic       halt;
      logic       is_ex;
   } wb_entry_t;

endpackage

// File: rtl/vector_writeback_unit_if.sv
// Producer (execute + load pipes) and register-file side of the writeback unit.
interface vector_writeback_unit_if
   import vector_writeback_unit_pkg::*;
#(
   parameter int NUM_LANES = VWB_NUM_LANES,
   parameter int LANE_W    = VWB_LANE_W,
   parameter int REG_ID_W  = VWB_REG_ID_W,
   parameter int DEPTH     = 4
);
   localparam int VW = NUM_LANES * LANE_W;
   localparam int OW = $clog2(DEPTH) + 1;

   logic                ex_valid;
   logic                ex_ready;
   logic [REG_ID_W-1:0] ex_id;
   logic [VW-1:0]       ex_value;
   flags_reg_t          ex_flags;
   logic                ex_halt;

   logic                mem_valid;
   logic                mem_ready;
   logic [REG_ID_W-1:0] mem_id;
   logic [VW-1:0]       mem_value;

   logic                rf_wr_en;
   logic [REG_ID_W-1:0] rf_wr_id;
   logic [VW-1:0]       rf_wr_value;
   logic                rf_mark_valid;
   logic                rf_flags_en;
   flags_reg_t          rf_flags;
   logic                rf_set_halt;
   logic                halted;
   logic                err_bad_reg;
   logic [OW-1:0]       occupancy;

   modport master (
      output ex_valid, ex_id, ex_value, ex_flags, ex_halt,
      output mem_valid, mem_id, mem_value,
      input  ex_ready, mem_ready,
      input  rf_wr_en, rf_wr_id, rf_wr_value, rf_mark_valid, rf_flags_en, rf_flags,
      input  rf_set_halt, halted, err_bad_reg, occupancy
   );

   modport slave (
      input  ex_valid, ex_id, ex_value, ex_flags, ex_halt,
      input  mem_valid, mem_id, mem_value,
      output ex_ready, mem_ready,
      output rf_wr_en, rf_wr_id, rf_wr_value, rf_mark_valid, rf_flags_en, rf_flags,
      output rf_set_halt, halted, err_bad_reg, occupancy
   );

endinterface

// File: rtl/vector_writeback_unit_wb_fifo.sv
// Writeback FIFO: one read port, up to two in-order writes per cycle.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module wb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    wr_a_en,
   input  logic [W-1:0]            wr_a_data,
   input  logic                    wr_b_en,
   input  logic [W-1:0]            wr_b_data,
   input  logic                    rd_en,
   output logic [W-1:0]            rd_data,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  occupancy
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
   logic [AW-1:0]             wa, wb;

   assign empty     = (wptr_q == rptr_q);
   assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign occupancy = wptr_q - rptr_q;
   assign rd_data   = mem_q[rptr_q[AW-1:0]];

   // Slot b always follows slot a; the caller only raises wr_b_en together with wr_a_en.
   always_comb begin
      mem_d = mem_q;
      wa    = wptr_q[AW-1:0];
      wb    = wa + AW'(1);
      if (wr_a_en) mem_d[wa] = wr_a_data;
      if (wr_b_en) mem_d[wb] = wr_b_data;
      wptr_d = wptr_q + PW'(wr_a_en) + PW'(wr_b_en);
      rptr_d = rptr_q + PW'(rd_en && !empty);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/vector_writeback_unit.sv
// Vector writeback stage: arbitrates execute/load results into a small FIFO
// and retires the head entry into the register file every cycle.
module vector_writeback_unit
   import vector_writeback_unit_pkg::*;
#(
   parameter int          NUM_LANES  = VWB_NUM_LANES,
   parameter int          LANE_W     = VWB_LANE_W,
   parameter int          REG_ID_W   = VWB_REG_ID_W,
   parameter int unsigned MAX_REG_ID = VWB_MAX_REG_ID,
   parameter int          DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   vector_writeback_unit_if.slave bus
);
   localparam int VW = NUM_LANES * LANE_W;
   localparam int OW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [REG_ID_W-1:0] id;
      logic [VW-1:0]       value;
      flags_reg_t          flags;
      logic                halt;
      logic                is_ex;
   } slot_t;

   localparam int SW = $bits(slot_t);

   slot_t         ex_slot, mem_slot, wr_a, wr_b, head;
   logic          ex_rdy, mem_rdy, ex_fire, mem_fire;
   logic          fifo_empty, fifo_full, head_vld, head_legal, head_ex;
   logic [OW-1:0] occ;
   logic          rr_q, rr_d;
   logic          halted_q, halted_d;
   logic          err_q, err_d;

   // rr_q == 0 favours ex when only one slot is left.
   always_comb begin
      ex_rdy  = 1'b0;
      mem_rdy = 1'b0;
      rr_d    = rr_q;
      if (!halted_q && !fifo_full) begin
         if (occ != OW'(DEPTH - 1)) begin
            ex_rdy  = 1'b1;
            mem_rdy = 1'b1;
         end else if (bus.ex_valid && !bus.mem_valid) begin
            ex_rdy = 1'b1;
         end else if (bus.mem_valid && !bus.ex_valid) begin
            mem_rdy = 1'b1;
         end else begin
            // Both requesting (flip pointer) or neither (grant is moot, pointer holds).
            ex_rdy  = !rr_q;
            mem_rdy = rr_q;
            if (bus.ex_valid) rr_d = !rr_q;
         end
      end
   end

   assign ex_fire  = bus.ex_valid  && ex_rdy;
   assign mem_fire = bus.mem_valid && mem_rdy;

   always_comb begin
      ex_slot  = '{id: bus.ex_id, value: bus.ex_value, flags: bus.ex_flags,
                   halt: bus.ex_halt, is_ex: 1'b1};
      mem_slot = '{id: bus.mem_id, value: bus.mem_value, flags: '0,
                   halt: 1'b0, is_ex: 1'b0};
      // Load result is older than the execute result when both land together.
      wr_a     = mem_fire ? mem_slot : ex_slot;
      wr_b     = ex_slot;
   end

   wb_fifo #(.W(SW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_a_en   (ex_fire || mem_fire),
      .wr_a_data (wr_a),
      .wr_b_en   (ex_fire && mem_fire),
      .wr_b_data (wr_b),
      .rd_en     (head_vld),
      .rd_data   (head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .occupancy (occ)
   );

   assign head_vld   = !fifo_empty;
   assign head_legal = (32'(head.id) < MAX_REG_ID);
   assign head_ex    = head_vld && head.is_ex;

   assign bus.ex_ready      = ex_rdy;
   assign bus.mem_ready     = mem_rdy;
   assign bus.rf_wr_en      = head_vld && head_legal;
   assign bus.rf_mark_valid = head_vld && head_legal;
   assign bus.rf_wr_id      = head_vld ? head.id    : '0;
   assign bus.rf_wr_value   = head_vld ? head.value : '0;
   assign bus.rf_flags_en   = head_ex && (head.flags != '0);
   assign bus.rf_flags      = head_ex ? head.flags : '0;
   assign bus.rf_set_halt   = head_ex && head.halt;
   assign bus.halted        = halted_q;
   assign bus.err_bad_reg   = err_q;
   assign bus.occupancy     = occ;

   always_comb begin
      halted_d = halted_q || (head_ex && head.halt);
      err_d    = err_q || (head_vld && !head_legal);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_q     <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rr_q     <= rr_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then constrained-random traffic.
module tb_vector_writeback_unit;
   localparam int NL    = 8;
   localparam int LW    = 64;
   localparam int RW    = 6;
   localparam int MAXR  = 32;
   localparam int DEPTH = 4;
   localparam int VW    = NL * LW;

   typedef struct {
      logic [RW-1:0] id;
      logic [VW-1:0] value;
      logic [63:0]   flags;
      logic          halt;
   } ment_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ment_t mq[$];
   bit    mvalid = 0, m_halted = 0, m_err = 0, m_rr = 0;
   bit    e_er = 0, e_mr = 0, e_contend = 0;
   int    exn = 0, memn = 0, last_g = -1;

   always #5 clk = ~clk;

   vector_writeback_unit_if #(.NUM_LANES(NL), .LANE_W(LW), .REG_ID_W(RW), .DEPTH(DEPTH)) bus ();

   vector_writeback_unit #(
      .NUM_LANES(NL), .LANE_W(LW), .REG_ID_W(RW), .MAX_REG_ID(MAXR), .DEPTH(DEPTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] rnd_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic idle();
      bus.ex_valid  = 1'b0;
      bus.mem_valid = 1'b0;
      bus.ex_halt   = 1'b0;
      bus.ex_flags  = 64'h0;
   endtask

   // Settle inputs, then compare every output against the queue model.
   task automatic eval();
      int    occ, fr;
      ment_t h;
      #1;
      e_er = 0; e_mr = 0; e_contend = 0;
      if (!mvalid) return;
      occ = mq.size();
      fr  = DEPTH - occ;
      if (m_halted || fr == 0) begin
         e_er = 0; e_mr = 0;
      end else if (fr >= 2) begin
         e_er = 1; e_mr = 1;
      end else if (bus.ex_valid && !bus.mem_valid) begin
         e_er = 1;
      end else if (bus.mem_valid && !bus.ex_valid) begin
         e_mr = 1;
      end else begin
         e_er = !m_rr; e_mr = m_rr;
         e_contend = bus.ex_valid && bus.mem_valid;
      end
      chk("ex_ready",  512'(bus.ex_ready),  512'(e_er));
      chk("mem_ready", 512'(bus.mem_ready), 512'(e_mr));
      chk("occupancy", 512'(bus.occupancy), 512'(occ));
      if (occ > 0) begin
         h = mq[0];
         chk("rf_wr_en",      512'(bus.rf_wr_en),      512'(h.id < MAXR));
         chk("rf_mark_valid", 512'(bus.rf_mark_valid), 512'(h.id < MAXR));
         chk("rf_wr_id",      512'(bus.rf_wr_id),      512'(h.id));
         chk("rf_wr_value",   512'(bus.rf_wr_value),   512'(h.value));
         chk("rf_flags_en",   512'(bus.rf_flags_en),   512'(h.flags != 0));
         chk("rf_flags",      512'(bus.rf_flags),      512'(h.flags));
         chk("rf_set_halt",   512'(bus.rf_set_halt),   512'(h.halt));
      end else begin
         chk("rf_wr_en_idle",    512'(bus.rf_wr_en),      512'(0));
         chk("rf_mark_idle",     512'(bus.rf_mark_valid), 512'(0));
         chk("rf_flags_en_idle", 512'(bus.rf_flags_en),   512'(0));
         chk("rf_halt_idle",     512'(bus.rf_set_halt),   512'(0));
      end
      chk("halted",      512'(bus.halted),      512'(m_halted));
      chk("err_bad_reg", 512'(bus.err_bad_reg), 512'(m_err));
   endtask

   // Apply this cycle's edge to the model, then move past the DUT edge.
   task automatic adv();
      ment_t h;
      if (!reset_n) begin
         mq.delete();
         m_halted = 0; m_err = 0; m_rr = 0; mvalid = 1;
      end else if (mvalid) begin
         if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.halt) m_halted = 1;
            if (h.id >= MAXR) m_err = 1;
         end
         if (e_contend) m_rr = !m_rr;
         if (bus.mem_valid && e_mr) begin
            h.id = bus.mem_id; h.value = bus.mem_value; h.flags = 64'h0; h.halt = 1'b0;
            mq.push_back(h);
         end
         if (bus.ex_valid && e_er) begin
            h.id = bus.ex_id; h.value = bus.ex_value; h.flags = bus.ex_flags; h.halt = bus.ex_halt;
            mq.push_back(h);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Random producer that holds its offer while stalled (or occasionally withdraws it).
   task automatic rnd_inputs();
      if (!(bus.ex_valid && !e_er)) begin
         bus.ex_valid = ($urandom_range(0, 99) < 60);
         bus.ex_id    = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(32, 63)) : RW'($urandom_range(0, 31));
         bus.ex_value = rnd_vec();
         bus.ex_flags = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'h0;
         bus.ex_halt  = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
         bus.ex_valid = 1'b0;
      end
      if (!(bus.mem_valid && !e_mr)) begin
         bus.mem_valid = ($urandom_range(0, 99) < 60);
         bus.mem_id    = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(32, 63)) : RW'($urandom_range(0, 31));
         bus.mem_value = rnd_vec();
      end else if ($urandom_range(0, 7) == 0) begin
         bus.mem_valid = 1'b0;
      end
      reset_n = ($urandom_range(0, 299) != 0);
   endtask

   initial begin
      idle();
      bus.ex_id = '0; bus.ex_value = '0; bus.mem_id = '0; bus.mem_value = '0;
      reset_n = 1'b0;
      eval(); adv();
      eval(); adv();
      reset_n = 1'b1;

      // Reset state
      eval();
      chk("rst_ex_ready",  512'(bus.ex_ready),    512'(1));
      chk("rst_mem_ready", 512'(bus.mem_ready),   512'(1));
      chk("rst_occ",       512'(bus.occupancy),   512'(0));
      chk("rst_wr_en",     512'(bus.rf_wr_en),    512'(0));
      chk("rst_halted",    512'(bus.halted),      512'(0));
      chk("rst_err",       512'(bus.err_bad_reg), 512'(0));
      adv();

      // Single ex write
      bus.ex_valid = 1'b1; bus.ex_id = 6'd3; bus.ex_value = {64{8'hA5}}; bus.ex_flags = 64'h0;
      eval(); adv();
      idle();
      eval();
      chk("single_wr_en",   512'(bus.rf_wr_en),      512'(1));
      chk("single_mark",    512'(bus.rf_mark_valid), 512'(1));
      chk("single_id",      512'(bus.rf_wr_id),      512'(3));
      chk("single_value",   512'(bus.rf_wr_value),   {64{8'hA5}});
      chk("single_flagsen", 512'(bus.rf_flags_en),   512'(0));
      adv();
      eval();
      chk("single_drained", 512'(bus.rf_wr_en),  512'(0));
      chk("single_occ0",    512'(bus.occupancy), 512'(0));
      adv();

      // Dual enqueue: load goes ahead of execute
      bus.ex_valid = 1'b1; bus.ex_id = 6'd1; bus.ex_value = rnd_vec();
      bus.mem_valid = 1'b1; bus.mem_id = 6'd2; bus.mem_value = rnd_vec();
      eval();
      chk("dual_ex_rdy",  512'(bus.ex_ready),  512'(1));
      chk("dual_mem_rdy", 512'(bus.mem_ready), 512'(1));
      adv();
      idle();
      eval();
      chk("dual_first_id", 512'(bus.rf_wr_id),  512'(2));
      chk("dual_occ2",     512'(bus.occupancy), 512'(2));
      adv();
      eval();
      chk("dual_second_id", 512'(bus.rf_wr_id),  512'(1));
      chk("dual_occ1",      512'(bus.occupancy), 512'(1));
      adv();
      eval();
      chk("dual_occ0", 512'(bus.occupancy), 512'(0));
      adv();

      // Illegal id with flags
      bus.ex_valid = 1'b1; bus.ex_id = 6'd40; bus.ex_value = rnd_vec(); bus.ex_flags = 64'h4;
      eval(); adv();
      idle();
      eval();
      chk("bad_wr_en",    512'(bus.rf_wr_en),    512'(0));
      chk("bad_flags_en", 512'(bus.rf_flags_en), 512'(1));
      chk("bad_flags",    512'(bus.rf_flags),    512'(64'h4));
      adv();
      for (int i = 0; i < 3; i++) begin
         eval();
         chk("bad_err_sticky", 512'(bus.err_bad_reg), 512'(1));
         adv();
      end

      // Backpressure: both producers always offering
      exn = 0; memn = 0; last_g = -1;
      for (int i = 0; i < 40; i++) begin
         bus.ex_valid = 1'b1;  bus.ex_id  = RW'(1 + exn % 15);   bus.ex_value  = {16{32'(exn * 7 + 1)}};
         bus.mem_valid = 1'b1; bus.mem_id = RW'(16 + memn % 16); bus.mem_value = {16{32'(memn * 5 + 3)}};
         eval();
         chk("bp_occ_max", 512'(bus.occupancy <= 4), 512'(1));
         if (bus.occupancy == 3) begin
            chk("bp_one_grant", 512'(bus.ex_ready ^ bus.mem_ready), 512'(1));
            if (last_g >= 0) chk("bp_alternate", 512'(bus.ex_ready), 512'(last_g == 0));
            last_g = int'(bus.ex_ready);
         end
         if (bus.ex_ready)  exn++;
         if (bus.mem_ready) memn++;
         adv();
      end

      // Reset with three entries queued
      idle();
      reset_n = 1'b0;
      eval();
      chk("mid_occ3", 512'(bus.occupancy), 512'(3));
      adv();
      reset_n = 1'b1;
      eval();
      chk("mid_occ0",      512'(bus.occupancy),   512'(0));
      chk("mid_wr_en",     512'(bus.rf_wr_en),    512'(0));
      chk("mid_halted",    512'(bus.halted),      512'(0));
      chk("mid_err",       512'(bus.err_bad_reg), 512'(0));
      chk("mid_ex_ready",  512'(bus.ex_ready),    512'(1));
      chk("mid_mem_ready", 512'(bus.mem_ready),   512'(1));
      adv();
      for (int i = 0; i < 3; i++) begin
         eval();
         chk("mid_no_ghost", 512'(bus.rf_wr_en), 512'(0));
         adv();
      end

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         rnd_inputs();
         eval(); adv();
      end

      // Drain, then halt followed by a younger load
      idle();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         eval(); adv();
      end
      bus.ex_valid = 1'b1; bus.ex_id = 6'd5; bus.ex_value = rnd_vec(); bus.ex_halt = 1'b1;
      eval(); adv();
      idle();
      bus.mem_valid = 1'b1; bus.mem_id = 6'd7; bus.mem_value = rnd_vec();
      eval();
      chk("halt_pulse",   512'(bus.rf_set_halt), 512'(1));
      chk("halt_mem_rdy", 512'(bus.mem_ready),   512'(1));
      adv();
      idle();
      eval();
      chk("halt_pulse_once", 512'(bus.rf_set_halt), 512'(0));
      chk("halt_sticky",     512'(bus.halted),      512'(1));
      chk("halt_young_id",   512'(bus.rf_wr_id),    512'(7));
      chk("halt_young_wr",   512'(bus.rf_wr_en),    512'(1));
      adv();
      for (int i = 0; i < 10; i++) begin
         bus.ex_valid = 1'b1;  bus.ex_id  = RW'(i);
         bus.mem_valid = 1'b1; bus.mem_id = RW'(i + 10);
         eval();
         chk("halt_ex_blocked",  512'(bus.ex_ready),  512'(0));
         chk("halt_mem_blocked", 512'(bus.mem_ready), 512'(0));
         adv();
      end
      idle();
      eval();
      chk("halt_occ0", 512'(bus.occupancy), 512'(0));
      adv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
